// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: accepts (address, word) pairs from a host, writes each
// word as four little-endian byte writes, and holds the core in reset until the image is in.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic             reload,
  output logic             mem_we,
  output logic [31:0]      mem_waddr,
  output logic [7:0]       mem_wdata,
  output logic             core_rst,
  output logic             running,
  output logic             ld_err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {StWait, StWr0, StWr1, StWr2, StWr3, StRun} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             last_q, last_d;
  logic             err_d;
  logic [CNT_W-1:0] cnt_d;
  logic             hs, legal;
  logic             wr_d;
  logic [1:0]       idx_d;

  assign hs    = ld_valid && ld_ready;
  assign legal = (ld_addr[1:0] == 2'b00) && (ld_addr <= MEM_BYTES - 4);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = ld_err;
    cnt_d   = words_loaded;
    case (state_q)
      StWait: begin
        if (hs) begin
          addr_d = ld_addr;
          data_d = ld_data;
          last_d = ld_last;
          if (legal) begin
            state_d = StWr0;
          end else begin
            // Dropped word: flag it, but an illegal last word still ends the image.
            err_d = 1'b1;
            if (ld_last) state_d = StRun;
          end
        end
      end
      StWr0: state_d = StWr1;
      StWr1: state_d = StWr2;
      StWr2: state_d = StWr3;
      StWr3: begin
        cnt_d   = words_loaded + 1'b1;
        state_d = last_q ? StRun : StWait;
      end
      StRun: begin
        if (reload) begin
          state_d = StWait;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Byte lane for the write cycle being entered.
  always_comb begin
    wr_d  = 1'b1;
    idx_d = 2'd0;
    case (state_d)
      StWr0:   idx_d = 2'd0;
      StWr1:   idx_d = 2'd1;
      StWr2:   idx_d = 2'd2;
      StWr3:   idx_d = 2'd3;
      default: wr_d  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StWait;
      addr_q       <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      ld_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      core_rst     <= 1'b1;
      running      <= 1'b0;
      ld_err       <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      ld_ready     <= (state_d == StWait);
      mem_we       <= wr_d;
      core_rst     <= (state_d != StRun);
      running      <= (state_d == StRun);
      ld_err       <= err_d;
      words_loaded <= cnt_d;
      if (wr_d) begin
        mem_waddr <= addr_d + {30'd0, idx_d};
        mem_wdata <= data_d[8*idx_d +: 8];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a word-level model predicts every output each cycle, and
// directed sequences pin boot timing, dropped words, stalls, reload and asynchronous reset.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned AW        = $clog2(MEM_BYTES);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ld_valid = 1'b0;
  logic [31:0]      ld_addr = '0;
  logic [31:0]      ld_data = '0;
  logic             ld_last = 1'b0;
  logic             reload = 1'b0;
  logic             ld_ready, mem_we, core_rst, running, ld_err;
  logic [31:0]      mem_waddr;
  logic [7:0]       mem_wdata;
  logic [CNT_W-1:0] words_loaded;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .reload(reload), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .core_rst(core_rst), .running(running),
    .ld_err(ld_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory as written by the DUT, and the image the host intended.
  logic [7:0] tb_mem  [MEM_BYTES] = '{default: 8'h00};
  logic [7:0] ref_img [MEM_BYTES] = '{default: 8'h00};
  int cyc = 0;
  int hs_n = 0;
  int last_hs = 0;
  int we_n = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && ld_valid && ld_ready) begin
      hs_n++;
      last_hs = cyc;
    end
    if (!rst && mem_we) begin
      tb_mem[mem_waddr[AW-1:0]] = mem_wdata;
      we_n++;
    end
  end

  // Word-level model: either running, or busy for m_left more byte writes, or idle.
  bit               m_run = 1'b0;
  int               m_left = 0;
  logic [31:0]      m_addr = '0;
  logic [31:0]      m_data = '0;
  bit               m_last = 1'b0;
  bit               m_err = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a <= MEM_BYTES - 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_left = 0; m_err = 0; m_cnt = '0;
    end else if (m_run) begin
      if (reload) begin
        m_run = 0; m_err = 0; m_cnt = '0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_cnt++;
        if (m_last) m_run = 1;
      end
    end else if (ld_valid) begin
      if (is_legal(ld_addr)) begin
        m_left = 4; m_addr = ld_addr; m_data = ld_data; m_last = ld_last;
      end else begin
        m_err = 1;
        if (ld_last) m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    int k;
    logic [31:0] sh;
    k = 4 - m_left;
    sh = m_data >> (8 * k);
    chk("ld_ready", ld_ready, !m_run && m_left == 0);
    chk("mem_we", mem_we, m_left > 0);
    chk("core_rst", core_rst, !m_run);
    chk("running", running, m_run);
    chk("ld_err", ld_err, m_err);
    chk("words_loaded", words_loaded, m_cnt);
    if (m_left > 0) begin
      chk("mem_waddr", mem_waddr, m_addr + k);
      chk("mem_wdata", mem_wdata, sh[7:0]);
    end
  end

  // Present a word and wait (bounded) for its handshake; returns the handshake cycle.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic l,
                      output int hc);
    int n0 = hs_n;
    int t = 0;
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = l;
    while (hs_n == n0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (hs_n == n0) chk("handshake_timeout", 0, 1);
    hc = last_hs;
    if (is_legal(a)) for (int i = 0; i < 4; i++) ref_img[a + i] = 8'(d >> (8 * i));
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Edges until core_rst is seen low, bounded.
  task automatic edges_to_run(output int k);
    k = 0;
    while (core_rst && k < 30) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hc, hc2, k, n0, w0, bad;
    int hcs [8];
    logic [31:0] w, a;
    logic [7:0] old2;

    repeat (2) @(negedge clk);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_words", words_loaded, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single word image.
    send(32'h0, 32'h0020_0113, 1'b1, hc);
    ld_valid = 1'b0;
    edges_to_run(k);
    chk("t1_edges_to_run", k, 4);  // core_rst low in the cycle after edge E+4
    chk("t1_words", words_loaded, 1);
    chk("t1_b0", tb_mem[0], 8'h13);
    chk("t1_b1", tb_mem[1], 8'h01);
    chk("t1_b2", tb_mem[2], 8'h20);
    chk("t1_b3", tb_mem[3], 8'h00);
    pulse_reload();

    // Dropped words, then legal boundary last word.
    w0 = we_n;
    send(32'h6, 32'hDEAD_BEEF, 1'b0, hc);
    send(MEM_BYTES - 2, 32'hCAFE_F00D, 1'b0, hc);
    ld_valid = 1'b0;
    @(negedge clk);
    chk("t3_no_writes", we_n - w0, 0);
    chk("t3_err", ld_err, 1);
    chk("t3_words", words_loaded, 0);
    send(MEM_BYTES - 4, 32'h1122_3344, 1'b1, hc);
    ld_valid = 1'b0;
    edges_to_run(k);
    chk("t3_released", running, 1);
    chk("t3_words_after", words_loaded, 1);
    chk("t3_top_byte", tb_mem[MEM_BYTES - 1], 8'h11);

    // Reload with ld_valid already high: handshake must land one cycle after reload.
    n0 = hs_n;
    ld_valid = 1'b1; ld_addr = 32'h100; ld_data = 32'h5566_7788; ld_last = 1'b1;
    pulse_reload();
    chk("rl_core_rst", core_rst, 1);
    chk("rl_ready", ld_ready, 1);
    chk("rl_err_clear", ld_err, 0);
    chk("rl_words_clear", words_loaded, 0);
    chk("rl_no_hs_in_run", hs_n - n0, 0);
    @(negedge clk);
    chk("rl_hs_next", hs_n - n0, 1);
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) ref_img[32'h100 + i] = 8'(32'h5566_7788 >> (8 * i));
    edges_to_run(k);
    chk("rl_released", running, 1);
    pulse_reload();

    // Back-to-back stream of 8 words.
    for (int i = 0; i < 8; i++) begin
      send(32'(4 * i), $urandom, i == 7, hc);
      hcs[i] = hc;
    end
    ld_valid = 1'b0;
    for (int i = 1; i < 8; i++) chk("t2_hs_spacing", hcs[i] - hcs[i-1], 5);
    edges_to_run(k);
    chk("t2_edges_to_run", k, 4);
    chk("t2_words", words_loaded, 8);
    chk("t2_running", running, 1);
    pulse_reload();

    // Stall: data wiggles during the writes; only the captured word may land.
    n0 = hs_n;
    send(32'h200, 32'hA1B2_C3D4, 1'b0, hc);
    for (int i = 0; i < 3; i++) begin
      ld_data = $urandom;
      @(negedge clk);
    end
    send(32'h204, 32'h0BAD_F00D, 1'b1, hc2);
    ld_valid = 1'b0;
    chk("stall_spacing", hc2 - hc, 5);
    chk("stall_hs_count", hs_n - n0, 2);
    edges_to_run(k);
    chk("stall_b0", tb_mem[32'h200], 8'hD4);
    chk("stall_b1", tb_mem[32'h201], 8'hC3);
    chk("stall_b2", tb_mem[32'h202], 8'hB2);
    chk("stall_b3", tb_mem[32'h203], 8'hA1);
    pulse_reload();

    // Random image with dropped words, idle gaps and ignored reload pulses.
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 7) a = 32'($urandom_range(0, MEM_BYTES / 4 - 1) * 4);
      else if (r == 7) a = 32'($urandom_range(0, MEM_BYTES / 4 - 1) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'(MEM_BYTES + 4 * $urandom_range(0, 100));
      else a = 32'hFFFF_FFFC;
      send(a, $urandom, i == 39, hc);
      if (i != 39) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0;
          reload = 1'($urandom_range(0, 1));
          @(negedge clk);
          reload = 1'b0;
        end
      end
    end
    ld_valid = 1'b0;
    edges_to_run(k);
    chk("rand_released", running, 1);
    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (tb_mem[i] !== ref_img[i]) bad++;
    chk("image_bytes_bad", bad, 0);
    pulse_reload();

    // Asynchronous reset during the third byte write.
    old2 = ref_img[32'h302];
    w = {8'h9A, ~old2, 8'h56, 8'h78};
    send(32'h300, w, 1'b1, hc);
    ld_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_core_rst", core_rst, 1);
    chk("arst_ready", ld_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_after_ready", ld_ready, 1);
    chk("arst_after_words", words_loaded, 0);
    chk("arst_after_err", ld_err, 0);
    chk("arst_b0", tb_mem[32'h300], 8'h78);
    chk("arst_b1", tb_mem[32'h301], 8'h56);
    chk("arst_b2_unwritten", tb_mem[32'h302], old2);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
